// File: rtl/issue_scheduler.sv
// Single-entry issue stage: holds one decoded instruction, checks it against a 32-bit register scoreboard,
// and strobes the target execution unit once RAW/WAW, unit-busy and in-flight limits allow; wrong-path tags are dropped on flush.
package issue_pkg;
    typedef enum logic [2:0] {FMT_R = 3'd0, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;
    typedef enum logic [2:0] {XU_ADD = 3'd0, XU_LOGIC, XU_SHIFT, XU_BRANCH, XU_MEM, XU_BYPASS} xu_t;
endpackage

module issue_scheduler
    import issue_pkg::*;
#(
    parameter int MAX_INFLIGHT = 8,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [4:0]       regA,
    input  logic [4:0]       regB,
    input  logic [4:0]       regD,
    input  fmt_t             fmt_in,
    input  xu_t              xu_sel,
    input  logic [3:0]       tag_in,
    input  logic [5:0]       xu_busy,
    output logic [5:0]       issue_valid,
    output logic [4:0]       issue_rd,
    output logic [3:0]       issue_tag,
    input  logic             wb_valid,
    input  logic [4:0]       wb_reg,
    input  logic             flush_in,
    input  logic [3:0]       flush_tag,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [3:0]       inflight
);

    typedef enum logic [1:0] {S_RUN = 2'd0, S_STALL, S_FLUSH} state_t;

    typedef struct packed {
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] rd;
        fmt_t       fmt;
        xu_t        xu;
        logic [3:0] tag;
    } hold_t;

    localparam logic [3:0] MAX_Q = 4'(MAX_INFLIGHT);

    state_t            state_q;
    hold_t             hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic [31:0]       sb_q, sb_d;
    logic [3:0]        cur_tag_q;
    logic [3:0]        inflight_q, inflight_d;
    logic [CNT_W-1:0]  stall_q;
    logic [5:0]        issue_valid_q;
    logic [4:0]        issue_rd_q;
    logic [3:0]        issue_tag_q;

    logic reads_a, reads_b, writes_d, hazard, room, fire, load, inc, dec;

    always_comb begin
        reads_a  = 1'b0;
        reads_b  = 1'b0;
        writes_d = 1'b0;
        case (hold_q.fmt)
            FMT_R:        begin reads_a = 1'b1; reads_b = 1'b1; writes_d = 1'b1; end
            FMT_I:        begin reads_a = 1'b1; writes_d = 1'b1; end
            FMT_S, FMT_B: begin reads_a = 1'b1; reads_b = 1'b1; end
            FMT_U, FMT_J: writes_d = 1'b1;
            default:      ;
        endcase
    end

    // x0 can never be set in sb_q, so it never causes a hazard
    assign hazard = (reads_a & sb_q[hold_q.ra]) | (reads_b & sb_q[hold_q.rb])
                  | (writes_d & sb_q[hold_q.rd]);
    assign room   = !writes_d || (inflight_q < MAX_Q);
    assign fire   = hold_vld_q && (hold_q.tag == cur_tag_q) && !hazard
                  && !xu_busy[hold_q.xu] && room && (state_q != S_FLUSH) && !flush_in;

    assign ready_out = (!hold_vld_q || fire) && (state_q != S_FLUSH) && !reset;
    assign load      = valid_in && ready_out;

    assign inc = fire && writes_d && (hold_q.rd != 5'd0);
    assign dec = wb_valid && (wb_reg != 5'd0) && (inflight_q != 4'd0);

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (load) begin
            hold_d     = '{ra: regA, rb: regB, rd: regD, fmt: fmt_in, xu: xu_sel, tag: tag_in};
            hold_vld_d = 1'b1;
        end else if (fire) begin
            hold_vld_d = 1'b0;
        end
        // wrong-path instructions are discarded at the flush edge, including one loaded on it
        if (flush_in && (hold_d.tag != flush_tag))
            hold_vld_d = 1'b0;

        sb_d = sb_q;
        if (inc)
            sb_d[hold_q.rd] = 1'b1;
        if (wb_valid && (wb_reg != 5'd0))
            sb_d[wb_reg] = 1'b0;

        inflight_d = inflight_q;
        if (inc && !dec)
            inflight_d = inflight_q + 4'd1;
        else if (dec && !inc)
            inflight_d = inflight_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RUN;
            hold_q        <= '0;
            hold_vld_q    <= 1'b0;
            sb_q          <= '0;
            cur_tag_q     <= '0;
            inflight_q    <= '0;
            stall_q       <= '0;
            issue_valid_q <= '0;
            issue_rd_q    <= '0;
            issue_tag_q   <= '0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            sb_q       <= sb_d;
            inflight_q <= inflight_d;

            issue_valid_q <= fire ? (6'b000001 << hold_q.xu) : 6'b000000;
            issue_rd_q    <= (fire && writes_d) ? hold_q.rd : 5'd0;
            issue_tag_q   <= fire ? hold_q.tag : 4'd0;

            if ((state_q == S_STALL) && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + 1'b1;

            if (flush_in) begin
                state_q   <= S_FLUSH;
                cur_tag_q <= flush_tag;
            end else begin
                case (state_q)
                    S_RUN:   if (hold_vld_q && !fire) state_q <= S_STALL;
                    S_STALL: if (fire) state_q <= S_RUN;
                    default: state_q <= S_RUN;
                endcase
            end
        end
    end

    assign issue_valid  = issue_valid_q;
    assign issue_rd     = issue_rd_q;
    assign issue_tag    = issue_tag_q;
    assign stall_cycles = stall_q;
    assign inflight     = inflight_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: issue latency, RAW stall, unit busy, flush, in-flight limit, mid-run reset.
module tb_issue_scheduler;
    import issue_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_out;
    logic [4:0]  regA, regB, regD;
    fmt_t        fmt_in;
    xu_t         xu_sel;
    logic [3:0]  tag_in;
    logic [5:0]  xu_busy;
    logic [5:0]  issue_valid;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_tag;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic        flush_in;
    logic [3:0]  flush_tag;
    logic [15:0] stall_cycles;
    logic [3:0]  inflight;

    int checks = 0;
    int passes = 0;

    issue_scheduler #(.MAX_INFLIGHT(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
        .regA(regA), .regB(regB), .regD(regD), .fmt_in(fmt_in), .xu_sel(xu_sel),
        .tag_in(tag_in), .xu_busy(xu_busy), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .issue_tag(issue_tag), .wb_valid(wb_valid),
        .wb_reg(wb_reg), .flush_in(flush_in), .flush_tag(flush_tag),
        .stall_cycles(stall_cycles), .inflight(inflight)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input fmt_t f, input xu_t x, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [3:0] t);
        valid_in = 1'b1; fmt_in = f; xu_sel = x; regA = a; regB = b; regD = d; tag_in = t;
    endtask

    task automatic do_reset;
        reset = 1'b1; valid_in = 1'b0; wb_valid = 1'b0; flush_in = 1'b0; xu_busy = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        reset = 1'b1;
        tick();
        checks++; if (issue_valid !== 6'd0) $display("FAIL rst_issue_valid: got %b want 000000", issue_valid); else passes++;
        checks++; if (inflight !== 4'd0) $display("FAIL rst_inflight: got %0d want 0", inflight); else passes++;
        checks++; if (stall_cycles !== 16'd0) $display("FAIL rst_stall: got %0d want 0", stall_cycles); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (ready_out !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready_out); else passes++;
    endtask

    task automatic test_issue;
        do_reset();
        put(FMT_R, XU_ADD, 5'd1, 5'd2, 5'd3, 4'd0);
        tick();
        valid_in = 1'b0;
        checks++; if (issue_valid !== 6'd0) $display("FAIL iss_early: got %b want 000000", issue_valid); else passes++;
        tick();
        checks++; if (issue_valid !== 6'b000001) $display("FAIL iss_valid: got %b want 000001", issue_valid); else passes++;
        checks++; if (issue_rd !== 5'd3) $display("FAIL iss_rd: got %0d want 3", issue_rd); else passes++;
        checks++; if (issue_tag !== 4'd0) $display("FAIL iss_tag: got %0d want 0", issue_tag); else passes++;
        checks++; if (inflight !== 4'd1) $display("FAIL iss_inflight: got %0d want 1", inflight); else passes++;
        tick();
        checks++; if (issue_valid !== 6'd0) $display("FAIL iss_onecycle: got %b want 000000", issue_valid); else passes++;
        wb_valid = 1'b1; wb_reg = 5'd3;
        tick();
        wb_valid = 1'b0;
        checks++; if (inflight !== 4'd0) $display("FAIL iss_wb_inflight: got %0d want 0", inflight); else passes++;
    endtask

    task automatic test_raw;
        do_reset();
        put(FMT_R, XU_ADD, 5'd1, 5'd2, 5'd3, 4'd0);
        tick();
        put(FMT_R, XU_ADD, 5'd3, 5'd1, 5'd4, 4'd0);
        checks++; if (ready_out !== 1'b1) $display("FAIL raw_ready_fire: got %b want 1", ready_out); else passes++;
        tick();
        valid_in = 1'b0;
        checks++; if (issue_rd !== 5'd3) $display("FAIL raw_first_rd: got %0d want 3", issue_rd); else passes++;
        tick();
        checks++; if (issue_valid !== 6'd0) $display("FAIL raw_held: got %b want 000000", issue_valid); else passes++;
        checks++; if (ready_out !== 1'b0) $display("FAIL raw_ready_held: got %b want 0", ready_out); else passes++;
        tick();
        tick();
        checks++; if (stall_cycles !== 16'd2) $display("FAIL raw_stall: got %0d want 2", stall_cycles); else passes++;
        wb_valid = 1'b1; wb_reg = 5'd3;
        tick();
        wb_valid = 1'b0;
        checks++; if (issue_valid !== 6'd0) $display("FAIL raw_no_forward: got %b want 000000", issue_valid); else passes++;
        tick();
        checks++; if (issue_valid !== 6'b000001) $display("FAIL raw_issue: got %b want 000001", issue_valid); else passes++;
        checks++; if (issue_rd !== 5'd4) $display("FAIL raw_rd: got %0d want 4", issue_rd); else passes++;
        checks++; if (stall_cycles !== 16'd4) $display("FAIL raw_stall_end: got %0d want 4", stall_cycles); else passes++;
        checks++; if (inflight !== 4'd1) $display("FAIL raw_inflight: got %0d want 1", inflight); else passes++;
    endtask

    task automatic test_unit_busy;
        do_reset();
        xu_busy = 6'b010000;
        put(FMT_I, XU_MEM, 5'd1, 5'd0, 5'd5, 4'd0);
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ready_out !== 1'b0 || issue_valid !== 6'd0)
                $display("FAIL busy_hold[%0d]: got ready=%b issue=%b want ready=0 issue=000000", i, ready_out, issue_valid);
            else passes++;
            tick();
        end
        xu_busy = 6'd0;
        checks++; if (stall_cycles !== 16'd3) $display("FAIL busy_stall_pre: got %0d want 3", stall_cycles); else passes++;
        tick();
        checks++; if (issue_valid !== 6'b010000) $display("FAIL busy_issue: got %b want 010000", issue_valid); else passes++;
        checks++; if (issue_rd !== 5'd5) $display("FAIL busy_rd: got %0d want 5", issue_rd); else passes++;
        checks++; if (stall_cycles !== 16'd4) $display("FAIL busy_stall: got %0d want 4", stall_cycles); else passes++;
    endtask

    task automatic test_flush;
        do_reset();
        put(FMT_B, XU_BRANCH, 5'd1, 5'd2, 5'd0, 4'd2);
        tick();
        valid_in = 1'b0;
        tick();
        checks++; if (issue_valid !== 6'd0) $display("FAIL fl_wrongtag: got %b want 000000", issue_valid); else passes++;
        flush_in = 1'b1; flush_tag = 4'd3;
        tick();
        flush_in = 1'b0;
        put(FMT_R, XU_ADD, 5'd1, 5'd2, 5'd7, 4'd3);
        checks++; if (ready_out !== 1'b0) $display("FAIL fl_ready: got %b want 0", ready_out); else passes++;
        checks++; if (issue_valid !== 6'd0) $display("FAIL fl_issue: got %b want 000000", issue_valid); else passes++;
        tick();
        checks++; if (ready_out !== 1'b1) $display("FAIL fl_ready_after: got %b want 1", ready_out); else passes++;
        checks++; if (issue_valid !== 6'd0) $display("FAIL fl_dropped: got %b want 000000", issue_valid); else passes++;
        tick();
        valid_in = 1'b0;
        tick();
        checks++; if (issue_valid !== 6'b000001) $display("FAIL fl_newpath: got %b want 000001", issue_valid); else passes++;
        checks++; if (issue_tag !== 4'd3) $display("FAIL fl_tag: got %0d want 3", issue_tag); else passes++;
        checks++; if (issue_rd !== 5'd7) $display("FAIL fl_rd: got %0d want 7", issue_rd); else passes++;
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            put(FMT_R, XU_ADD, 5'd0, 5'd0, 5'(i), 4'd0);
            tick();
            if (i >= 2) begin
                checks++; if (issue_valid !== 6'b000001 || issue_rd !== 5'(i - 1))
                    $display("FAIL b2b_issue[%0d]: got valid=%b rd=%0d want valid=000001 rd=%0d", i, issue_valid, issue_rd, i - 1);
                else passes++;
            end
        end
        valid_in = 1'b0;
        checks++; if (inflight !== 4'd8) $display("FAIL b2b_inflight8: got %0d want 8", inflight); else passes++;
        tick();
        checks++; if (issue_valid !== 6'd0) $display("FAIL b2b_limit: got %b want 000000", issue_valid); else passes++;
        checks++; if (ready_out !== 1'b0) $display("FAIL b2b_limit_ready: got %b want 0", ready_out); else passes++;
        wb_valid = 1'b1; wb_reg = 5'd1;
        tick();
        wb_valid = 1'b0;
        checks++; if (issue_valid !== 6'd0 || inflight !== 4'd7)
            $display("FAIL b2b_wb: got valid=%b inflight=%0d want valid=000000 inflight=7", issue_valid, inflight);
        else passes++;
        tick();
        checks++; if (issue_valid !== 6'b000001 || issue_rd !== 5'd9)
            $display("FAIL b2b_ninth: got valid=%b rd=%0d want valid=000001 rd=9", issue_valid, issue_rd);
        else passes++;
        checks++; if (inflight !== 4'd8) $display("FAIL b2b_inflight_back: got %0d want 8", inflight); else passes++;
        put(FMT_S, XU_MEM, 5'd10, 5'd11, 5'd12, 4'd0);
        tick();
        valid_in = 1'b0;
        tick();
        checks++; if (issue_valid !== 6'b010000 || issue_rd !== 5'd0)
            $display("FAIL b2b_store: got valid=%b rd=%0d want valid=010000 rd=0", issue_valid, issue_rd);
        else passes++;
        checks++; if (inflight !== 4'd8) $display("FAIL b2b_store_inflight: got %0d want 8", inflight); else passes++;
    endtask

    task automatic test_reset_mid;
        // relies on test_back_to_back leaving x2..x9 pending
        put(FMT_R, XU_ADD, 5'd2, 5'd3, 5'd10, 4'd0);
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        checks++; if (stall_cycles === 16'd0) $display("FAIL mid_stall_pre: got 0 want nonzero"); else passes++;
        reset = 1'b1;
        tick();
        checks++; if (issue_valid !== 6'd0 || issue_rd !== 5'd0 || issue_tag !== 4'd0)
            $display("FAIL mid_outputs: got valid=%b rd=%0d tag=%0d want 0", issue_valid, issue_rd, issue_tag);
        else passes++;
        checks++; if (inflight !== 4'd0 || stall_cycles !== 16'd0)
            $display("FAIL mid_counters: got inflight=%0d stall=%0d want 0", inflight, stall_cycles);
        else passes++;
        reset = 1'b0;
        #1;
        checks++; if (ready_out !== 1'b1) $display("FAIL mid_ready: got %b want 1", ready_out); else passes++;
        put(FMT_R, XU_ADD, 5'd2, 5'd3, 5'd11, 4'd0);
        tick();
        valid_in = 1'b0;
        tick();
        checks++; if (issue_valid !== 6'b000001 || issue_rd !== 5'd11)
            $display("FAIL mid_sb_clear: got valid=%b rd=%0d want valid=000001 rd=11", issue_valid, issue_rd);
        else passes++;
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; regA = '0; regB = '0; regD = '0;
        fmt_in = FMT_R; xu_sel = XU_ADD; tag_in = '0; xu_busy = '0;
        wb_valid = 1'b0; wb_reg = '0; flush_in = 1'b0; flush_tag = '0;
        test_reset();
        test_issue();
        test_raw();
        test_unit_busy();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
